// File: rtl/miter_seq_monitor.sv
// Gold/gate sequential miter: per-lane masked compare, sticky error flag, saturating counters.
// Latency: 1 cycle from accepted sample to registered mismatch/counter/capture outputs.
// Backpressure: none; a sample can be accepted every cycle, clear wins over valid_in.
// Optional: define MITER_FIRST_CAPTURE_EN to build first-mismatch capture (else first_* read 0).
module miter_seq_monitor #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      valid_in,
  input  logic [CHANNELS*WIDTH-1:0] gold_in,
  input  logic [CHANNELS*WIDTH-1:0] gate_in,
  input  logic [CHANNELS*WIDTH-1:0] dc_mask,
  output logic [CHANNELS-1:0]       mismatch_vec,
  output logic                      mismatch_any,
  output logic                      err_sticky,
  output logic [CNT_W-1:0]          err_count,
  output logic [CNT_W-1:0]          sample_count,
  output logic [CH_W-1:0]           first_chan,
  output logic [CNT_W-1:0]          first_idx,
  output logic [WIDTH-1:0]          first_gold,
  output logic [WIDTH-1:0]          first_gate
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] lane_mis;
  logic [CHANNELS-1:0] mvec_d, mvec_q;
  logic                any_d, any_q;
  logic                sticky_d, sticky_q;
  logic [CNT_W-1:0]    err_cnt_d, err_cnt_q;
  logic [CNT_W-1:0]    samp_cnt_d, samp_cnt_q;

  // Per-lane compare; don't-care bits never contribute to a mismatch
  always_comb begin
    lane_mis = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lane_mis[c] = |((gold_in[c*WIDTH +: WIDTH] ^ gate_in[c*WIDTH +: WIDTH])
                      & ~dc_mask[c*WIDTH +: WIDTH]);
    end
  end

  // Next state of result register, sticky flag and saturating counters
  always_comb begin
    mvec_d     = mvec_q;
    any_d      = any_q;
    sticky_d   = sticky_q;
    err_cnt_d  = err_cnt_q;
    samp_cnt_d = samp_cnt_q;
    if (clear) begin
      mvec_d     = '0;
      any_d      = 1'b0;
      sticky_d   = 1'b0;
      err_cnt_d  = '0;
      samp_cnt_d = '0;
    end else if (valid_in) begin
      mvec_d = lane_mis;
      any_d  = |lane_mis;
      if (samp_cnt_q != CNT_MAX) samp_cnt_d = samp_cnt_q + CNT_W'(1);
      if (|lane_mis) begin
        sticky_d = 1'b1;
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  // Result and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mvec_q     <= '0;
      any_q      <= 1'b0;
      sticky_q   <= 1'b0;
      err_cnt_q  <= '0;
      samp_cnt_q <= '0;
    end else begin
      mvec_q     <= mvec_d;
      any_q      <= any_d;
      sticky_q   <= sticky_d;
      err_cnt_q  <= err_cnt_d;
      samp_cnt_q <= samp_cnt_d;
    end
  end

  assign mismatch_vec = mvec_q;
  assign mismatch_any = any_q;
  assign err_sticky   = sticky_q;
  assign err_count    = err_cnt_q;
  assign sample_count = samp_cnt_q;

`ifdef MITER_FIRST_CAPTURE_EN
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CAPTURED = 1'b1;

  logic [0:0]       state_d, state_q;
  logic [CH_W-1:0]  low_idx;
  logic [WIDTH-1:0] low_gold, low_gate;
  logic [CH_W-1:0]  fchan_d, fchan_q;
  logic [CNT_W-1:0] fidx_d, fidx_q;
  logic [WIDTH-1:0] fgold_d, fgold_q;
  logic [WIDTH-1:0] fgate_d, fgate_q;

  // Pick the lowest-index failing lane: scan downward so the lowest hit wins
  always_comb begin
    low_idx  = '0;
    low_gold = '0;
    low_gate = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (lane_mis[c]) begin
        low_idx  = CH_W'(c);
        low_gold = gold_in[c*WIDTH +: WIDTH];
        low_gate = gate_in[c*WIDTH +: WIDTH];
      end
    end
  end

  // Capture FSM: latch only the first failing sample after reset/clear
  always_comb begin
    state_d = state_q;
    fchan_d = fchan_q;
    fidx_d  = fidx_q;
    fgold_d = fgold_q;
    fgate_d = fgate_q;
    if (clear) begin
      state_d = IDLE;
      fchan_d = '0;
      fidx_d  = '0;
      fgold_d = '0;
      fgate_d = '0;
    end else if (valid_in && (|lane_mis) && (state_q == IDLE)) begin
      state_d = CAPTURED;
      fchan_d = low_idx;
      fidx_d  = samp_cnt_q;
      fgold_d = low_gold;
      fgate_d = low_gate;
    end
  end

  // Capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fchan_q <= '0;
      fidx_q  <= '0;
      fgold_q <= '0;
      fgate_q <= '0;
    end else begin
      state_q <= state_d;
      fchan_q <= fchan_d;
      fidx_q  <= fidx_d;
      fgold_q <= fgold_d;
      fgate_q <= fgate_d;
    end
  end

  assign first_chan = fchan_q;
  assign first_idx  = fidx_q;
  assign first_gold = fgold_q;
  assign first_gate = fgate_q;
`else
  assign first_chan = '0;
  assign first_idx  = '0;
  assign first_gold = '0;
  assign first_gate = '0;
`endif

endmodule

// File: doc/miter_seq_monitor.md
# miter_seq_monitor

Parametrised sequential gold/gate comparison monitor for the jpeg_encoder equivalence flow. It compares CHANNELS lanes of WIDTH-bit gold and gate values per valid sample, honouring a per-bit don't-care mask, and flags mismatches on a registered output. It also keeps saturating mismatch and sample counters and can optionally capture the first failing sample. It sits beside partitioned netlists (for example the dct_unit macu mult_res registers) in simulation and emulation benches, where a purely combinational miter cannot track behaviour across cycles.

## Interface
Parameters:
- WIDTH, 16, bits per channel
- CHANNELS, 4, number of compared lanes (≥1)
- CNT_W, 16, width of the mismatch and sample counters

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of counters, sticky flag and capture
- valid_in  in  1  sample qualifier
- gold_in  in  CHANNELS*WIDTH  reference values; lane c occupies bits [c*WIDTH +: WIDTH]
- gate_in  in  CHANNELS*WIDTH  implementation values, same packing as gold_in
- dc_mask  in  CHANNELS*WIDTH  1 = bit is don't-care (gold undefined), excluded from compare
- mismatch_vec  out  CHANNELS  per-lane mismatch for the last valid sample
- mismatch_any  out  1  OR of mismatch_vec
- err_sticky  out  1  set on the first mismatch, held until clear
- err_count  out  CNT_W  number of mismatching samples, saturating
- sample_count  out  CNT_W  number of accepted samples, saturating
- first_chan  out  max(1,$clog2(CHANNELS))  lane of the first mismatch
- first_idx  out  CNT_W  sample_count value at the first mismatch
- first_gold  out  WIDTH  gold value of first_chan at the first mismatch
- first_gate  out  WIDTH  gate value of first_chan at the first mismatch

## Operation
- Lane c mismatches when ((gold_c ^ gate_c) & ~dc_c) != 0.
- Accepted sample: valid_in=1 and clear=0.
- On an accepted sample:
  - mismatch_vec is loaded with the per-lane result.
  - sample_count increments.
  - If any lane mismatches, err_count increments and err_sticky is set.
- Cycles with valid_in=0: mismatch_vec, mismatch_any and both counters hold.
- Both counters saturate at 2^CNT_W-1. They do not wrap, and err_sticky is unaffected by saturation.
- First-capture state machine, states IDLE and CAPTURED:
  - IDLE → CAPTURED on the first accepted sample with any mismatch. That sample's data is latched into the first_* outputs.
  - first_chan is the lowest-index mismatching lane.
  - first_idx is the pre-increment sample_count.
  - CAPTURED holds until clear or reset.
- clear=1:
  - Zeroes the counters, mismatch_vec, err_sticky and all first_* outputs.
  - Returns the state machine to IDLE.
  - clear has priority over valid_in. A sample presented in the same cycle is discarded and not counted.
- dc_mask all ones: every lane always matches.

## Timing
- Latency is 1 cycle. A sample at edge t drives mismatch_vec, mismatch_any, the counters and the first_* outputs after edge t. mismatch_any is registered, not combinational.
- Reset (rst_n=0) forces every output to 0 and the state machine to IDLE immediately, independent of clk.
- Reset mid-sample: the sample is lost and nothing is retained.
- Release of rst_n is synchronous to the next clk edge. A sample is accepted on the first rising edge with rst_n=1.
- Back-to-back valid samples are accepted every cycle. There is no backpressure.

## Configuration
- MITER_FIRST_CAPTURE_EN defined: the first-capture state machine and the first_chan, first_idx, first_gold and first_gate registers are built as described.
- MITER_FIRST_CAPTURE_EN undefined:
  - No capture registers are built.
  - first_* outputs are tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Reset check: WIDTH=16, CHANNELS=4, all inputs held at 0xFFFF with rst_n low → every output reads 0. After rst_n rises, one valid matching sample → sample_count=1, err_count=0.
- Single-lane mismatch: lane 2 gold=0x1234, gate=0x1235, mask=0, at sample index 5 →
  - next cycle: mismatch_vec=4'b0100, mismatch_any=1, err_sticky=1, err_count=1
  - first_chan=2, first_idx=5, first_gold=0x1234, first_gate=0x1235
- Don't-care masking: lane 0 gold=0x00F0, gate=0x00F1, mask=0x0001 → no mismatch and err_count unchanged. With mask=0x0000 → mismatch.
- First capture held: mismatch on lane 3, then on lane 1 two samples later → first_chan stays 3 and err_count=2. Mismatches on lanes 1 and 3 in the same sample → first_chan=1.
- Saturation: CNT_W=4, 20 mismatching samples → err_count=15 and sample_count=15, both held.
- clear with valid: clear=1 and valid_in=1 with a mismatching sample → all counters, err_sticky and first_* read 0 next cycle, and the sample is not counted. The next mismatch is captured fresh with first_idx=0.
